// File: rtl/mpss_bus_pkg.sv
// rtl/mpss_bus_pkg.sv - shared types and constants for the MPSS req/ack/resp bus
// Purpose: bus widths, the packed command record carried through the command
// FIFO, and the initiator FSM state encoding.
package mpss_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;

  // Field order fixes the packed layout: {we, addr, be, wdata}.
  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_BE_W-1:0]   be;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_cmd_t;

  localparam int BUS_CMD_W = 1 + BUS_ADDR_W + BUS_BE_W + BUS_DATA_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/mpss_cmd_fifo.sv
// rtl/mpss_cmd_fifo.sv - synchronous command FIFO
// Purpose: in-order buffer of bus commands between the client port and the bus FSM.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset (flushes the FIFO)
//   push_i        write wdata_i (ignored when full)
//   wdata_i       entry to store
//   pop_i         drop the head entry (ignored when empty)
//   rdata_o       head entry, valid while empty_o = 0
//   full_o        occupancy = DEPTH
//   empty_o       occupancy = 0
//   count_o       current occupancy
module mpss_cmd_fifo
  import mpss_bus_pkg::*;
#(
  parameter int WIDTH = BUS_CMD_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - command-queued initiator for the MPSS req/ack/resp bus
// Purpose: accepts client read/write commands, queues them, issues them in order
// on the bus with at most MAX_RD_OUT unanswered reads, and returns read data.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               client command handshake
//   cmd_we/cmd_addr/cmd_be/cmd_wdata  client command fields
//   rsp_valid/rsp_rdata               one-cycle read-data pulse, data held after
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata  bus request, held until bus_ack
//   bus_ack                           request accepted
//   bus_resp/bus_rdata                in-order read response
//   busy_o                            work queued, in flight or reads outstanding
//   err_o                             sticky: response with no read outstanding
module bus_initiator
  import mpss_bus_pkg::*;
#(
  parameter int CMD_DEPTH  = 4,
  parameter int MAX_RD_OUT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [BUS_ADDR_W-1:0] cmd_addr,
  input  logic [BUS_BE_W-1:0]   cmd_be,
  input  logic [BUS_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [BUS_DATA_W-1:0] rsp_rdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [BUS_ADDR_W-1:0] bus_addr,
  output logic [BUS_BE_W-1:0]   bus_be,
  output logic [BUS_DATA_W-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic                  bus_resp,
  input  logic [BUS_DATA_W-1:0] bus_rdata,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(CMD_DEPTH);
  localparam logic [2:0]    RD_MAX   = 3'(MAX_RD_OUT);

  bus_state_e state_q, state_d;
  bus_cmd_t   bus_q, bus_d, head, cmd_in;
  logic       bus_req_q, bus_req_d;
  logic [2:0] rd_cnt_q, rd_cnt_d;
  logic       cmd_ready_q, rsp_valid_q, busy_q, err_q;
  logic [BUS_DATA_W-1:0] rsp_rdata_q;

  logic          fifo_full, fifo_empty, push, pop;
  logic [CW-1:0] fifo_count, fifo_cnt_nxt;
  logic          rd_inc, resp_ok, head_elig;

  assign cmd_in = '{we: cmd_we, addr: cmd_addr, be: cmd_be, wdata: cmd_wdata};
  assign push   = cmd_valid && cmd_ready_q && !fifo_full;

  mpss_cmd_fifo #(
    .WIDTH (BUS_CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (cmd_in),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Outstanding-read accounting; a response with nothing outstanding is an error
  // and leaves the count untouched.
  assign rd_inc  = bus_req_q && bus_ack && !bus_q.we;
  assign resp_ok = bus_resp && (rd_cnt_q != '0);

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (rd_inc && !resp_ok) begin
      rd_cnt_d = rd_cnt_q + 3'd1;
    end else if (!rd_inc && resp_ok) begin
      rd_cnt_d = rd_cnt_q - 3'd1;
    end
  end

  // Uses the post-update count so a response this cycle frees a slot at this edge.
  assign head_elig = !fifo_empty && (head.we || (rd_cnt_d < RD_MAX));

  always_comb begin
    state_d   = state_q;
    bus_d     = bus_q;
    bus_req_d = bus_req_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_elig) begin
          pop       = 1'b1;
          bus_d     = head;
          bus_req_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          if (head_elig) begin
            pop   = 1'b1;
            bus_d = head;
          end else begin
            bus_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: begin
        bus_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    fifo_cnt_nxt = fifo_count;
    if (push && !pop) begin
      fifo_cnt_nxt = fifo_count + 1'b1;
    end else if (!push && pop) begin
      fifo_cnt_nxt = fifo_count - 1'b1;
    end
  end

  // cmd_ready and busy_o are registered from next-state values so they line up
  // with the occupancy they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      bus_q       <= '0;
      bus_req_q   <= 1'b0;
      rd_cnt_q    <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      bus_req_q   <= bus_req_d;
      rd_cnt_q    <= rd_cnt_d;
      cmd_ready_q <= (fifo_cnt_nxt != CNT_FULL);
      busy_q      <= (fifo_cnt_nxt != '0) || bus_req_d || (rd_cnt_d != '0);
      rsp_valid_q <= resp_ok;
      if (resp_ok) rsp_rdata_q <= bus_rdata;
      if (bus_resp && !resp_ok) err_q <= 1'b1;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_q.we;
  assign bus_addr  = bus_q.addr;
  assign bus_be    = bus_q.be;
  assign bus_wdata = bus_q.wdata;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule
